// File: rtl/matrix_led_pkg.sv
// matrix_led_pkg: shared types and helpers for the 8x8 LED matrix scan controller
package matrix_led_pkg;
  typedef logic [2:0] row_idx_t;
  typedef logic [7:0] col_bits_t;
  typedef enum logic [1:0] {DRIVE, BLANK_PRE, BLANK_POST} scan_state_t;
  function automatic col_bits_t onehot8(row_idx_t idx);
    return col_bits_t'(1) << idx;
  endfunction
endpackage

// File: rtl/matrix_scan_timer.sv
// matrix_scan_timer: row-slot counter, drive/guard FSM and row index sequencer
// Ports: i_clk, i_rst_n (async active-low); o_row_idx current row;
//   o_drive_en high in DRIVE; o_drive_start first DRIVE cycle of a slot;
//   o_row_advance mid-guard strobe; o_frame_wrap mid-guard strobe of the 7->0 advance.
module matrix_scan_timer
  import matrix_led_pkg::*;
#(
  parameter int ROW_PERIOD   = 27_000,
  parameter int GUARD_CYCLES = 540
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic [2:0] o_row_idx,
  output logic       o_drive_en,
  output logic       o_drive_start,
  output logic       o_row_advance,
  output logic       o_frame_wrap
);
  localparam int CW = $clog2(ROW_PERIOD);
  localparam logic [CW-1:0] C_LAST      = CW'(ROW_PERIOD - 1);
  localparam logic [CW-1:0] C_DRIVE_END = CW'(ROW_PERIOD - GUARD_CYCLES - 1);
  localparam logic [CW-1:0] C_MID       = CW'(ROW_PERIOD - GUARD_CYCLES / 2 - 1);
  scan_state_t    r_state;
  logic [CW-1:0]  r_cnt;
  row_idx_t       r_row_idx;
  // Mid-guard point; after reset the FSM sits in BLANK_POST for a whole slot,
  // so this also fires there and row 7 advances to 0 before the first DRIVE.
  assign o_row_advance = (r_state != DRIVE) && (r_cnt == C_MID);
  assign o_frame_wrap  = o_row_advance && (r_row_idx == 3'd7);
  assign o_drive_en    = (r_state == DRIVE);
  assign o_drive_start = o_drive_en && (r_cnt == '0);
  assign o_row_idx     = r_row_idx;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= BLANK_POST;
      r_cnt     <= '0;
      r_row_idx <= 3'd7;
    end else begin
      r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;
      if (o_row_advance) r_row_idx <= r_row_idx + 1'b1;
      case (r_state)
        DRIVE:     if (r_cnt == C_DRIVE_END) r_state <= BLANK_PRE;
        BLANK_PRE: if (r_cnt == C_MID) r_state <= BLANK_POST;
        default:   if (r_cnt == C_LAST) r_state <= DRIVE;
      endcase
    end
  end
endmodule

// File: rtl/matrix_scan_controller.sv
// matrix_scan_controller: double-buffered 8x8 LED matrix scanner with tear-free swap
// Ports: i_clk, i_rst_n (async active-low);
//   write port i_wr_valid/o_wr_ready/i_wr_row/i_wr_data into the back buffer;
//   i_swap_req level request, o_swap_ack 1-cycle pulse when buffers exchange;
//   o_frame_start pulse with row 0 on the pins; o_d column data, o_row active-low row select.
module matrix_scan_controller
  import matrix_led_pkg::*;
#(
  parameter int CLOCK_HZ     = 27_000_000,
  parameter int ROW_PERIOD   = CLOCK_HZ / 1000,
  parameter int GUARD_CYCLES = CLOCK_HZ / 50000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_wr_valid,
  output logic       o_wr_ready,
  input  logic [2:0] i_wr_row,
  input  logic [7:0] i_wr_data,
  input  logic       i_swap_req,
  output logic       o_swap_ack,
  output logic       o_frame_start,
  output logic [7:0] o_d,
  output logic [7:0] o_row
);
  logic [1:0][7:0][7:0] r_buf;
  logic                 r_front_sel;
  logic                 r_swap_ack;
  logic                 r_frame_start;
  col_bits_t            r_d;
  col_bits_t            r_row;
  row_idx_t             w_row_idx;
  logic                 w_drive_en;
  logic                 w_drive_start;
  logic                 w_row_advance;
  logic                 w_frame_wrap;
  logic                 w_pending;
  logic                 w_swap;
  matrix_scan_timer #(
    .ROW_PERIOD  (ROW_PERIOD),
    .GUARD_CYCLES(GUARD_CYCLES)
  ) u_timer (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .o_row_idx    (w_row_idx),
    .o_drive_en   (w_drive_en),
    .o_drive_start(w_drive_start),
    .o_row_advance(w_row_advance),
    .o_frame_wrap (w_frame_wrap)
  );
  // A request is spent on the cycle its ack is visible; a still-high level
  // after that counts as a fresh request.
  assign w_pending  = i_swap_req & ~r_swap_ack;
  // Writes stall while a swap waits, so a write and a swap never share a cycle.
  assign o_wr_ready = ~w_pending;
  assign w_swap     = w_row_advance & w_frame_wrap & w_pending;
  assign o_swap_ack    = r_swap_ack;
  assign o_frame_start = r_frame_start;
  assign o_d           = r_d;
  assign o_row         = r_row;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_buf         <= '0;
      r_front_sel   <= 1'b0;
      r_swap_ack    <= 1'b0;
      r_frame_start <= 1'b0;
      r_d           <= '0;
      r_row         <= '0;
    end else begin
      if (i_wr_valid && o_wr_ready) r_buf[~r_front_sel][i_wr_row] <= i_wr_data;
      if (w_swap) r_front_sel <= ~r_front_sel;
      r_swap_ack    <= w_swap;
      r_frame_start <= w_drive_start && (w_row_idx == 3'd0);
      r_d           <= w_drive_en ? r_buf[r_front_sel][w_row_idx] : '0;
      r_row         <= w_drive_en ? ~onehot8(w_row_idx) : '0;
    end
  end
endmodule

// File: tb/tb_matrix_scan_controller.sv
// tb_matrix_scan_controller: directed checks of scan timing, writes, swaps and reset
module tb_matrix_scan_controller;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic [2:0] wr_row = '0;
  logic [7:0] wr_data = '0;
  logic       swap_req = 1'b0;
  logic       wr_ready, swap_ack, frame_start;
  logic [7:0] d, row;
  int n_vec = 0, n_err = 0, cyc = 0, n_ack = 0, last_ack = -1;
  logic       ack_prev = 1'b0;
  logic [7:0] fr [8];
  logic [7:0] bk [8];
  logic [7:0] pat [8];
  matrix_scan_controller #(.ROW_PERIOD(20), .GUARD_CYCLES(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
    .i_wr_row(wr_row), .i_wr_data(wr_data), .i_swap_req(swap_req), .o_swap_ack(swap_ack),
    .o_frame_start(frame_start), .o_d(d), .o_row(row)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask
  // Pins for cycle c after reset release: first row slot lands on the pins at cycle 21,
  // each slot is 16 driven + 4 blank cycles, rows cycle 0..7.
  function automatic logic [7:0] exp_row(int c);
    int t;
    if (c < 21) return 8'd0;
    t = c - 21;
    return (t % 20 < 16) ? ~(8'd1 << ((t / 20) % 8)) : 8'd0;
  endfunction
  function automatic logic [7:0] exp_d(int c);
    int t;
    if (c < 21) return 8'd0;
    t = c - 21;
    return (t % 20 < 16) ? fr[(t / 20) % 8] : 8'd0;
  endfunction
  task automatic step();
    logic pend, exp_ack, t;
    pend = swap_req && !ack_prev;
    if (wr_valid && !pend) bk[wr_row] = wr_data;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    exp_ack = pend && cyc >= 18 && (cyc - 18) % 160 == 0;
    if (exp_ack)
      for (int i = 0; i < 8; i++) begin
        t = 1'b0;
        {fr[i], bk[i]} = {bk[i], fr[i]};
      end
    ack_prev = exp_ack;
    if (swap_ack) begin
      n_ack++;
      last_ack = cyc;
    end
    chk("ack", swap_ack, exp_ack);
    chk("row", row, exp_row(cyc));
    chk("d", d, exp_d(cyc));
    chk("frame_start", frame_start, cyc >= 21 && (cyc - 21) % 160 == 0);
    chk("wr_ready", wr_ready, !(swap_req && !exp_ack));
  endtask
  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    swap_req = 1'b0;
    wr_valid = 1'b0;
    #1;
    chk("rst_row", row, 8'd0);
    chk("rst_d", d, 8'd0);
    chk("rst_ready", wr_ready, 1'b1);
    chk("rst_ack", swap_ack, 1'b0);
    chk("rst_fs", frame_start, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    ack_prev = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fr[i] = 8'd0;
      bk[i] = 8'd0;
    end
  endtask
  task automatic wait_ack();
    for (int k = 0; k < 400; k++) begin
      step();
      if (swap_ack) break;
    end
  endtask
  initial begin
    pat[0] = 8'h81; pat[1] = 8'h42; pat[2] = 8'h24; pat[3] = 8'h18;
    pat[4] = 8'h18; pat[5] = 8'h24; pat[6] = 8'h42; pat[7] = 8'h81;
    @(negedge clk);
    do_reset();
    // reset in the middle of the first driven row
    run_to(25);
    chk("drive_row0", row, 8'hFE);
    do_reset();
    // two frames of plain scanning with empty buffers
    run_to(200);
    // load the back buffer then request a swap
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1;
      wr_row = 3'(i);
      wr_data = pat[i];
      step();
    end
    wr_valid = 1'b0;
    swap_req = 1'b1;
    n_ack = 0;
    wait_ack();
    swap_req = 1'b0;
    chk("swap_cyc", last_ack, 338);
    run_to(341);
    chk("pat_row0_d", d, 8'h81);
    chk("pat_row0_row", row, 8'hFE);
    run_to(361);
    chk("pat_row1_d", d, 8'h42);
    chk("swap_once", n_ack, 1);
    // late request during row 3 with a blocked write
    wr_valid = 1'b1; wr_row = 3'd0; wr_data = 8'h55;
    step();
    wr_valid = 1'b0;
    run_to(405);
    swap_req = 1'b1;
    wr_valid = 1'b1; wr_row = 3'd1; wr_data = 8'hAA;
    #1;
    chk("late_ready", wr_ready, 1'b0);
    wait_ack();
    swap_req = 1'b0;
    wr_valid = 1'b0;
    chk("late_cyc", last_ack, 498);
    run_to(501);
    chk("late_row0_d", d, 8'h55);
    run_to(521);
    chk("late_row1_d", d, 8'h00);
    // request raised on the advance cycle itself, then held
    run_to(657);
    swap_req = 1'b1;
    step();
    chk("race_ack", swap_ack, 1'b1);
    run_to(661);
    chk("race_d", d, 8'h81);
    wait_ack();
    swap_req = 1'b0;
    chk("hold_cyc", last_ack, 818);
    run_to(821);
    chk("hold_d", d, 8'h55);
    // reset while a swap is pending
    run_to(850);
    swap_req = 1'b1;
    run_to(860);
    do_reset();
    n_ack = 0;
    run_to(200);
    chk("post_rst_d", d, 8'h00);
    chk("post_rst_acks", n_ack, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
